// File: rtl/wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_buffer
//  Description : Circular writeback FIFO with per-register pending tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_reg1,
    input  logic [1:0]               in_reg2,
    input  logic                     in_en1,
    input  logic                     in_en2,
    input  logic [15:0]              in_data,
    input  logic                     wb_hold,
    output logic [1:0]               write_reg1,
    output logic [1:0]               write_reg2,
    output logic [15:0]              write_data,
    output logic                     write_en1,
    output logic                     write_en2,
    output logic [3:0]               busy,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    logic [1:0]       r_reg1 [DEPTH];
    logic [1:0]       r_reg2 [DEPTH];
    logic             r_en1  [DEPTH];
    logic             r_en2  [DEPTH];
    logic [15:0]      r_data [DEPTH];

    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_cw-1:0]  r_occ;

    logic             w_nonempty;
    logic             w_push;
    logic             w_pop;
    logic             w_en1_st;

    assign w_nonempty = (r_occ != '0);
    assign in_ready   = rst_n && (r_occ != c_full);
    assign w_push     = in_valid && in_ready && (in_en1 || in_en2);
    // Same-register double write collapses onto the LSB byte only
    assign w_en1_st   = in_en1 && !(in_en2 && (in_reg1 == in_reg2));

    assign write_reg1 = w_nonempty ? r_reg1[r_head] : 2'b00;
    assign write_reg2 = w_nonempty ? r_reg2[r_head] : 2'b00;
    assign write_data = w_nonempty ? r_data[r_head] : 16'h0000;
    assign write_en1  = rst_n && w_nonempty && !wb_hold && r_en1[r_head];
    assign write_en2  = rst_n && w_nonempty && !wb_hold && r_en2[r_head];
    assign w_pop      = write_en1 || write_en2;
    assign occupancy  = r_occ;

    // Payload storage is never reset; valid entries are tracked by r_occ
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg1[r_tail] <= in_reg1;
            r_reg2[r_tail] <= in_reg2;
            r_en1[r_tail]  <= w_en1_st;
            r_en2[r_tail]  <= in_en2;
            r_data[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_cw'(1);
                2'b01:   r_occ <= r_occ - c_cw'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_cnt
        logic            w_inc;
        logic            w_dec;
        logic [c_cw-1:0] w_cnt_nxt;
        logic [c_cw-1:0] r_cnt;
        logic            r_pend;

        assign w_inc = w_push && ((w_en1_st && (in_reg1 == 2'(r))) ||
                                  (in_en2   && (in_reg2 == 2'(r))));
        assign w_dec = w_pop  && ((r_en1[r_head] && (r_reg1[r_head] == 2'(r))) ||
                                  (r_en2[r_head] && (r_reg2[r_head] == 2'(r))));

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_inc && !w_dec) begin
                w_cnt_nxt = r_cnt + c_cw'(1);
            end else if (w_dec && !w_inc) begin
                w_cnt_nxt = r_cnt - c_cw'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_pend <= (w_cnt_nxt != '0);
            end
        end

        assign busy[r] = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_buffer
//  Description : Self-checking bench for wb_buffer (vectors + queue model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_reg1, in_reg2;
    logic        in_en1, in_en2;
    logic [15:0] in_data;
    logic        wb_hold;
    logic [1:0]  write_reg1, write_reg2;
    logic [15:0] write_data;
    logic        write_en1, write_en2;
    logic [3:0]  busy;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg1(in_reg1), .in_reg2(in_reg2), .in_en1(in_en1), .in_en2(in_en2),
        .in_data(in_data), .wb_hold(wb_hold),
        .write_reg1(write_reg1), .write_reg2(write_reg2), .write_data(write_data),
        .write_en1(write_en1), .write_en2(write_en2),
        .busy(busy), .occupancy(occupancy)
    );

    typedef struct packed {
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic        e1;
        logic        e2;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        logic        v;
        logic [1:0]  r1, r2;
        logic        e1, e2;
        logic [15:0] d;
        logic        h;
        logic        x_ready, x_we1, x_we2;
        logic [1:0]  x_wr2;
        logic [15:0] x_wd;
        logic [3:0]  x_busy;
        logic [2:0]  x_occ;
    } vec_t;

    ent_t q[$];
    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;
    bit   do_cmp = 1'b0;

    logic        cap_ready, cap_we1, cap_we2;
    logic [1:0]  cap_wr2;
    logic [15:0] cap_wd;
    logic [3:0]  cap_busy;
    logic [2:0]  cap_occ;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the queue model, then advance it
    task automatic cycle(input logic rn, input logic v, input logic [1:0] r1, input logic [1:0] r2,
                         input logic e1, input logic e2, input logic [15:0] d, input logic h);
        logic [3:0] eb;
        ent_t       hd;
        logic       pu;
        rst_n = rn; in_valid = v; in_reg1 = r1; in_reg2 = r2;
        in_en1 = e1; in_en2 = e2; in_data = d; wb_hold = h;
        @(negedge clk);
        cap_ready = in_ready; cap_we1 = write_en1; cap_we2 = write_en2;
        cap_wr2 = write_reg2; cap_wd = write_data; cap_busy = busy; cap_occ = occupancy;
        if (do_cmp) begin
            eb = 4'b0000;
            foreach (q[i]) begin
                if (q[i].e1) eb[q[i].r1] = 1'b1;
                if (q[i].e2) eb[q[i].r2] = 1'b1;
            end
            hd = (q.size() > 0) ? q[0] : '0;
            chk("m_in_ready",  32'(in_ready),   32'(rn && (q.size() != DEPTH)));
            chk("m_write_en1", 32'(write_en1),  32'(rn && !h && hd.e1));
            chk("m_write_en2", 32'(write_en2),  32'(rn && !h && hd.e2));
            chk("m_write_reg1", 32'(write_reg1), 32'(hd.r1));
            chk("m_write_reg2", 32'(write_reg2), 32'(hd.r2));
            chk("m_write_data", 32'(write_data), 32'(hd.d));
            chk("m_busy",      32'(busy),       32'(eb));
            chk("m_occupancy", 32'(occupancy),  32'(q.size()));
        end
        @(posedge clk);
        if (!rn) begin
            q.delete();
        end else begin
            pu = v && (q.size() != DEPTH) && (e1 || e2);
            if (q.size() > 0 && !h) void'(q.pop_front());
            if (pu) q.push_back('{r1, r2, e1 && !(e2 && (r1 == r2)), e2, d});
        end
        #1;
    endtask

    task automatic idle(input logic h);
        cycle(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, h);
    endtask

    initial begin
        //        v  r1 r2 e1 e2  d        h  rdy we1 we2 wr2 wd       busy     occ
        tbl[0] = '{1, 2, 3, 1, 1, 16'hA55A, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 16'h0000, 0, 1,  1,  1,  3, 16'hA55A, 4'b1100, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 16'h0000, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};
        tbl[3] = '{1, 1, 1, 1, 1, 16'h1234, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 16'h0000, 0, 1,  0,  1,  1, 16'h1234, 4'b0010, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 16'h0000, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};
        tbl[6] = '{1, 0, 0, 0, 0, 16'hFFFF, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 16'h0000, 0, 1,  0,  0,  0, 16'h0000, 4'b0000, 0};

        do_cmp = 1'b0;
        cycle(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        do_cmp = 1'b1;
        cycle(1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 16'h5555, 1'b0);
        chk("reset_in_ready", 32'(cap_ready), 32'd0);
        idle(1'b0);
        chk("post_reset_ready", 32'(cap_ready), 32'd1);
        chk("post_reset_occ",   32'(cap_occ),   32'd0);

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].e1, tbl[i].e2, tbl[i].d, tbl[i].h);
            chk($sformatf("tbl%0d_ready", i), 32'(cap_ready), 32'(tbl[i].x_ready));
            chk($sformatf("tbl%0d_we1", i),   32'(cap_we1),   32'(tbl[i].x_we1));
            chk($sformatf("tbl%0d_we2", i),   32'(cap_we2),   32'(tbl[i].x_we2));
            chk($sformatf("tbl%0d_wreg2", i), 32'(cap_wr2),   32'(tbl[i].x_wr2));
            chk($sformatf("tbl%0d_wdata", i), 32'(cap_wd),    32'(tbl[i].x_wd));
            chk($sformatf("tbl%0d_busy", i),  32'(cap_busy),  32'(tbl[i].x_busy));
            chk($sformatf("tbl%0d_occ", i),   32'(cap_occ),   32'(tbl[i].x_occ));
        end

        // Fill under hold, overflow attempt, then drain in order
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 1'b1, 2'(k), 2'((k + 1) % 4), 1'b1, 1'b1, 16'h1000 + 16'(k), 1'b1);
        cycle(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 16'hDEAD, 1'b1);
        chk("full_occ",   32'(cap_occ),   32'd4);
        chk("full_ready", 32'(cap_ready), 32'd0);
        idle(1'b1);
        chk("full_occ_after_extra", 32'(cap_occ), 32'd4);
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            chk($sformatf("drain%0d_we1", k),  32'(cap_we1), 32'd1);
            chk($sformatf("drain%0d_data", k), 32'(cap_wd),  32'h1000 + 32'(k));
        end
        idle(1'b0);
        chk("drain_occ", 32'(cap_occ), 32'd0);

        // Streaming: one push per cycle, buffer stays at depth one
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b1, 2'(k % 4), 2'((k * 3 + 1) % 4), 1'b1, (k % 3) != 0,
                  16'hB000 + 16'(k), 1'b0);
            if (k > 0) begin
                chk($sformatf("stream%0d_occ", k),   32'(cap_occ),   32'd1);
                chk($sformatf("stream%0d_ready", k), 32'(cap_ready), 32'd1);
            end
        end
        idle(1'b0);

        // Reset while three entries wait behind hold
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b1, 2'(k), 2'(3 - k), 1'b1, 1'b0, 16'hC000 + 16'(k), 1'b1);
        cycle(1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 16'hEEEE, 1'b0);
        chk("rst_mid_ready", 32'(cap_ready), 32'd0);
        chk("rst_mid_we",    32'(cap_we1 | cap_we2), 32'd0);
        idle(1'b0);
        chk("rst_mid_occ",  32'(cap_occ),  32'd0);
        chk("rst_mid_busy", 32'(cap_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            chk($sformatf("rst_after%0d_we", k), 32'(cap_we1 | cap_we2), 32'd0);
        end

        // Randomized traffic against the queue model
        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), $urandom_range(0, 9) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered writeback entries; legal values are powers of two, 2..8.
REQ-002 clk  in  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 in_valid  in  1  SHALL mean a writeback request is offered.
REQ-005 in_ready  out  1  SHALL mean the buffer accepts a request this cycle.
REQ-006 in_reg1, in_reg2  in  2 each  SHALL be the destination registers for the MSB and LSB bytes respectively.
REQ-007 in_en1, in_en2  in  1 each  SHALL be the per-byte write enables of the request.
REQ-008 in_data  in  16  SHALL be the result: [15:8] goes to in_reg1 and [7:0] goes to in_reg2.
REQ-009 wb_hold  in  1  SHALL block presentation of the head entry to the register file while high.
REQ-010 write_reg1, write_reg2  out  2 each  SHALL be the register-file write addresses.
REQ-011 write_data  out  16  SHALL be the register-file write data.
REQ-012 write_en1, write_en2  out  1 each  SHALL be the register-file write enables.
REQ-013 busy  out  4  SHALL set bit r high while any buffered entry holds an enabled write to register r.
REQ-014 occupancy  out  clog2(DEPTH)+1  SHALL be the number of valid entries.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries {reg1, reg2, en1, en2, data[15:0]}, with head and tail pointers that wrap modulo DEPTH.
REQ-016 in_ready SHALL equal (occupancy != DEPTH), decoded from registered state only; there is no path from the same cycle's pop.
REQ-017 A push SHALL occur on a rising edge when in_valid && in_ready && (in_en1 || in_en2).
REQ-018 A request with in_valid && in_ready and both enables low SHALL be accepted and discarded, with no entry and no change to busy.
REQ-019 When in_en1 && in_en2 && in_reg1 == in_reg2, the enqueued entry SHALL store en1 = 0, so the LSB byte wins deterministically.
REQ-020 Write outputs SHALL be combinational from the head entry; write_en1/write_en2 SHALL equal head en1/en2 when occupancy != 0 && !wb_hold, else 0.
REQ-021 write_reg1, write_reg2 and write_data SHALL show the head entry whenever occupancy != 0; otherwise they SHALL be 0.
REQ-022 A pop SHALL occur on the rising edge that ends a cycle in which (write_en1 || write_en2) was high, so each entry is presented for exactly one cycle.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; this is legal at any occupancy below DEPTH.
REQ-024 Latency: a request pushed at edge N into an empty buffer SHALL appear on the write outputs in the cycle after edge N (if wb_hold is low) and SHALL be popped at edge N+1.
REQ-025 busy SHALL be derived from per-register pending counters (width clog2(DEPTH)+1).
  - counter increments on push of an entry enabling that register.
  - counter decrements on pop of such an entry.
  - on a same-edge push and pop for one register, the counter is unchanged.
  - busy[r] = (count[r] != 0).
REQ-026 busy SHALL be registered, so it updates on the same edge as occupancy.
REQ-027 Order SHALL be strictly FIFO; wb_hold SHALL stall the head without reordering and SHALL NOT block pushes while not full.
REQ-028 Counter overflow and underflow SHALL be impossible by construction; no saturation logic is required.

Reset
REQ-029 When rst_n is low at a rising edge, the block SHALL clear occupancy, head, tail, all pending counters and busy to 0, regardless of in-flight pushes or pops.
REQ-030 While rst_n is low, in_ready SHALL be 0 and write_en1/write_en2 SHALL be 0; stored entry payloads need not be cleared.
REQ-031 In the first cycle after rst_n rises, in_ready SHALL be 1 and occupancy SHALL be 0.

Verification
REQ-032 Single push {reg1=2, reg2=3, en=11, data=16'hA55A} into empty buffer, wb_hold=0:
  - next cycle: write_en1=write_en2=1, write_data=16'hA55A, busy=4'b1100.
  - one edge later: occupancy=0, busy=0.
REQ-033 With wb_hold=1, push 4 entries:
  - occupancy=4, in_ready=0, a fifth in_valid is ignored.
  - release wb_hold: four writes appear in push order on consecutive cycles.
  - occupancy reaches 0 after 4 edges.
REQ-034 Push {reg1=1, reg2=1, en=11, data=16'h1234}: outputs write_en1=0, write_en2=1, write_reg2=1, write_data[7:0]=8'h34; busy=4'b0010.
REQ-035 Steady state: push every cycle with wb_hold=0, 10 requests with mixed destinations.
  - occupancy stays 1 and in_ready stays 1.
  - writes match input order.
  - busy tracks exactly; the pointer wrap is exercised.
REQ-036 Request with en=00 and in_valid=1: accepted (in_ready=1), occupancy unchanged, no write issued.
REQ-037 Reset mid-operation: with 3 entries and wb_hold=1, assert rst_n=0 for one edge.
  - occupancy=0 and busy=0.
  - no write_en is asserted after reset is released.
